port_rd_scheduler: RTL and testbench



---
 rtl/port_rd_scheduler_if.sv | 19 +
 rtl/port_rd_scheduler.sv | 108 ++++++++++
 tb/tb_port_rd_scheduler.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/port_rd_scheduler_if.sv
// Read-request handshake between one port's scheduler and the shared read datapath.
interface port_rd_scheduler_if;
  logic       ready;
  logic [7:0] queue_empty;
  logic       sched_req;
  logic [2:0] sched_prior;
  logic       sched_ack;
  logic       packet_done;

  modport master (
    input  ready, queue_empty, sched_ack, packet_done,
    output sched_req, sched_prior
  );

  modport slave (
    output ready, queue_empty, sched_ack, packet_done,
    input  sched_req, sched_prior
  );
endinterface

// File: rtl/port_rd_scheduler.sv
// Per-port read scheduler over 8 priority queues: strict priority or credit-based WRR,
// one outstanding packet-read request at a time.
module port_rd_scheduler #(
  parameter int BASE_WEIGHT = 8,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wrr_enable,
  port_rd_scheduler_if.master  rd,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] grant_count
);

  typedef enum logic [1:0] {IDLE, ARB, REQ, XFER} state_t;

  state_t               state, state_nxt;
  logic [3:0]           credit     [8];
  logic [3:0]           credit_nxt [8];
  logic                 sched_req_nxt;
  logic [2:0]           sched_prior_nxt;
  logic                 busy_nxt;
  logic [CNT_WIDTH-1:0] grant_count_nxt;
  logic [7:0]           cand;
  logic [2:0]           cand_idx;

  function automatic logic [3:0] weight(input int p);
    return 4'(BASE_WEIGHT - p);
  endfunction

  // Eligible queues; in WRR mode a queue with no credit left sits out until reload.
  always_comb begin
    cand     = '0;
    cand_idx = '0;
    for (int p = 0; p < 8; p++) begin
      cand[p] = ~rd.queue_empty[p] & (~wrr_enable | (credit[p] != 4'd0));
    end
    for (int p = 7; p >= 0; p--) begin
      if (cand[p]) cand_idx = 3'(p);
    end
  end

  always_comb begin
    state_nxt       = state;
    sched_req_nxt   = rd.sched_req;
    sched_prior_nxt = rd.sched_prior;
    busy_nxt        = busy;
    grant_count_nxt = grant_count;
    for (int p = 0; p < 8; p++) credit_nxt[p] = credit[p];

    case (state)
      IDLE: begin
        if (rd.ready && (rd.queue_empty != 8'hFF)) state_nxt = ARB;
      end
      ARB: begin
        if (cand != 8'h00) begin
          sched_prior_nxt = cand_idx;
          sched_req_nxt   = 1'b1;
          busy_nxt        = 1'b1;
          state_nxt       = REQ;
        end else if (rd.queue_empty != 8'hFF) begin
          // Every backlogged queue is out of credit: start a new round, select next cycle.
          for (int p = 0; p < 8; p++) credit_nxt[p] = weight(p);
        end else begin
          state_nxt = IDLE;
        end
      end
      REQ: begin
        if (rd.sched_ack) begin
          sched_req_nxt   = 1'b0;
          grant_count_nxt = grant_count + 1'b1;
          if (wrr_enable) credit_nxt[rd.sched_prior] = credit[rd.sched_prior] - 4'd1;
          state_nxt = XFER;
        end else if (rd.queue_empty[rd.sched_prior]) begin
          sched_req_nxt = 1'b0;
          busy_nxt      = 1'b0;
          state_nxt     = IDLE;
        end
      end
      XFER: begin
        if (rd.packet_done) begin
          busy_nxt  = 1'b0;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      rd.sched_req   <= 1'b0;
      rd.sched_prior <= 3'd0;
      busy           <= 1'b0;
      grant_count    <= '0;
      for (int p = 0; p < 8; p++) credit[p] <= weight(p);
    end else begin
      state          <= state_nxt;
      rd.sched_req   <= sched_req_nxt;
      rd.sched_prior <= sched_prior_nxt;
      busy           <= busy_nxt;
      grant_count    <= grant_count_nxt;
      for (int p = 0; p < 8; p++) credit[p] <= credit_nxt[p];
    end
  end

endmodule

// File: tb/tb_port_rd_scheduler.sv
// Directed bench for port_rd_scheduler: strict priority, WRR rounds, request withdrawal,
// reset during transfer and statistics-counter wrap.
module tb_port_rd_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        wrr_enable;
  logic        wrr_enable2;
  logic        busy;
  logic        busy2;
  logic [15:0] grant_count;
  logic [3:0]  grant_count2;

  int n_cmp = 0;
  int n_bad = 0;

  port_rd_scheduler_if rd_if ();
  port_rd_scheduler_if rd_if2 ();

  port_rd_scheduler #(.BASE_WEIGHT(8), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .wrr_enable(wrr_enable), .rd(rd_if.master),
    .busy(busy), .grant_count(grant_count)
  );

  // Narrow counter instance so the wrap can be reached in a short run.
  port_rd_scheduler #(.BASE_WEIGHT(8), .CNT_WIDTH(4)) dut2 (
    .clk(clk), .rst(rst), .wrr_enable(wrr_enable2), .rd(rd_if2.master),
    .busy(busy2), .grant_count(grant_count2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req(output int lat);
    lat = 0;
    while (!rd_if.sched_req && lat < 20) begin
      step();
      lat++;
    end
    chk("req_seen", 32'(rd_if.sched_req), 32'd1);
  endtask

  task automatic grant(input logic [2:0] ep, input int elat, input string tag);
    int lat;
    wait_req(lat);
    chk({tag, "_prior"}, 32'(rd_if.sched_prior), 32'(ep));
    chk({tag, "_lat"}, 32'(lat), 32'(elat));
    rd_if.sched_ack = 1'b1;
    step();
    rd_if.sched_ack   = 1'b0;
    rd_if.packet_done = 1'b1;
    step();
    rd_if.packet_done = 1'b0;
  endtask

  initial begin
    int lat;
    int n;
    logic seen;

    rst = 1'b1;
    wrr_enable = 1'b0;
    wrr_enable2 = 1'b0;
    rd_if.ready = 1'b1;       rd_if2.ready = 1'b1;
    rd_if.queue_empty = 8'hFF; rd_if2.queue_empty = 8'hFF;
    rd_if.sched_ack = 1'b0;   rd_if2.sched_ack = 1'b0;
    rd_if.packet_done = 1'b0; rd_if2.packet_done = 1'b0;
    step();
    step();
    rst = 1'b0;

    // Reset state and idling with all queues empty
    chk("rst_req", 32'(rd_if.sched_req), 32'd0);
    chk("rst_prior", 32'(rd_if.sched_prior), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_gc", 32'(grant_count), 32'd0);
    chk("rst_dut2_busy", 32'(busy2), 32'd0);
    chk("rst_dut2_prior", 32'(rd_if2.sched_prior), 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      seen = seen | rd_if.sched_req | busy;
    end
    chk("empty_no_req", 32'(seen), 32'd0);
    chk("empty_gc", 32'(grant_count), 32'd0);

    // Strict priority: q1 and q3 backlogged, q1 wins until it drains
    wrr_enable = 1'b0;
    rd_if.queue_empty = 8'b1111_0101;
    for (int i = 0; i < 3; i++) grant(3'd1, 2, "sp_q1");
    rd_if.queue_empty = 8'b1111_0111;
    grant(3'd3, 2, "sp_q3");
    rd_if.queue_empty = 8'hFF;
    chk("sp_gc", 32'(grant_count), 32'd4);
    chk("sp_credit1", 32'(dut.credit[1]), 32'd7);

    // WRR: q0 gets 8, q7 gets 1, then a reload cycle before q0 again
    rst = 1'b1;
    step();
    rst = 1'b0;
    wrr_enable = 1'b1;
    rd_if.queue_empty = 8'b0111_1110;
    for (int i = 0; i < 8; i++) grant(3'd0, 2, "wrr_q0");
    grant(3'd7, 2, "wrr_q7");
    grant(3'd0, 3, "wrr_reload_q0");
    rd_if.queue_empty = 8'hFF;
    chk("wrr_gc", 32'(grant_count), 32'd10);
    chk("wrr_credit0", 32'(dut.credit[0]), 32'd7);
    chk("wrr_credit7", 32'(dut.credit[7]), 32'd1);

    // Request withdrawn when its queue empties before ack
    rst = 1'b1;
    step();
    rst = 1'b0;
    rd_if.queue_empty = 8'b1111_1011;
    wait_req(lat);
    chk("wd_prior", 32'(rd_if.sched_prior), 32'd2);
    rd_if.ready = 1'b0;
    step();
    step();
    chk("ready_drop_hold_req", 32'(rd_if.sched_req), 32'd1);
    chk("ready_drop_hold_prior", 32'(rd_if.sched_prior), 32'd2);
    rd_if.ready = 1'b1;
    rd_if.queue_empty = 8'hFF;
    step();
    chk("wd_req", 32'(rd_if.sched_req), 32'd0);
    chk("wd_busy", 32'(busy), 32'd0);
    chk("wd_credit2", 32'(dut.credit[2]), 32'd6);
    chk("wd_gc", 32'(grant_count), 32'd0);

    // Ack and queue-empty together: ack wins
    rd_if.queue_empty = 8'b1111_1011;
    wait_req(lat);
    chk("race_prior", 32'(rd_if.sched_prior), 32'd2);
    rd_if.queue_empty = 8'hFF;
    rd_if.sched_ack = 1'b1;
    step();
    rd_if.sched_ack = 1'b0;
    chk("race_req", 32'(rd_if.sched_req), 32'd0);
    chk("race_busy", 32'(busy), 32'd1);
    chk("race_gc", 32'(grant_count), 32'd1);
    chk("race_credit2", 32'(dut.credit[2]), 32'd5);
    rd_if.packet_done = 1'b1;
    step();
    rd_if.packet_done = 1'b0;
    chk("race_done_busy", 32'(busy), 32'd0);

    // Reset in the middle of a transfer
    rd_if.queue_empty = 8'b1111_1110;
    wait_req(lat);
    rd_if.sched_ack = 1'b1;
    step();
    rd_if.sched_ack = 1'b0;
    chk("xfer_busy", 32'(busy), 32'd1);
    chk("xfer_credit0", 32'(dut.credit[0]), 32'd7);
    rst = 1'b1;
    step();
    rst = 1'b0;
    rd_if.queue_empty = 8'hFF;
    chk("xrst_busy", 32'(busy), 32'd0);
    chk("xrst_req", 32'(rd_if.sched_req), 32'd0);
    chk("xrst_gc", 32'(grant_count), 32'd0);
    for (int p = 0; p < 8; p++) chk($sformatf("xrst_credit%0d", p), 32'(dut.credit[p]), 32'(8 - p));

    // Counter wrap on the narrow instance: ack and done held high, one grant per 4 cycles
    rd_if2.queue_empty = 8'b1111_1110;
    rd_if2.sched_ack   = 1'b1;
    rd_if2.packet_done = 1'b1;
    n = 0;
    while (grant_count2 != 4'hF && n < 200) begin
      step();
      n++;
    end
    chk("gc2_max", 32'(grant_count2), 32'hF);
    n = 0;
    while (grant_count2 == 4'hF && n < 20) begin
      step();
      n++;
    end
    chk("gc2_wrap", 32'(grant_count2), 32'd0);
    rd_if2.queue_empty = 8'hFF;
    rd_if2.sched_ack   = 1'b0;
    rd_if2.packet_done = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
